// File: rtl/fsb_match_probe.sv
// fsb_match_probe: multi-channel FSB address match probe, qualified by address stability.
// Define FSB_MATCH_PROBE_HITCNT_EN to add per-channel hit counters and the CNT_DATA readback.
module fsb_match_probe #(
    parameter int AW     = 32,
    parameter int NCH    = 4,
    parameter int STABLE = 2,
    parameter int CW     = 16,
    parameter int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           FSBCLK,
    input  logic           nRST,
    input  logic           CPU_nAS,
    input  logic           INt,
    input  logic [AW-1:0]  FSB_A,
    input  logic           CFG_WE,
    input  logic [CHW-1:0] CFG_CH,
    input  logic           CFG_EN,
    input  logic [AW-1:0]  CFG_ADDR,
    input  logic [AW-1:0]  CFG_MASK,
    input  logic           CNT_CLR,
    input  logic [CHW-1:0] CNT_CH,
    output logic [NCH-1:0] MATCH,
    output logic           OUTt,
    output logic [CW-1:0]  CNT_DATA
);
    localparam logic [3:0] STABLE_V = 4'(STABLE);

    logic [AW-1:0]  a_r;
    logic [3:0]     scnt;
    logic [3:0]     scnt_nxt;
    logic           qual;
    logic           cfg_ok;
    logic [NCH-1:0] ch_en;
    logic [AW-1:0]  ch_addr [NCH];
    logic [AW-1:0]  ch_mask [NCH];
    logic [NCH-1:0] hit;
    logic [NCH-1:0] match_nxt;

    assign qual   = ~CPU_nAS & INt;
    assign cfg_ok = CFG_WE && (int'(CFG_CH) < NCH);

    // A new strobe or a moved address restarts the count at 1; otherwise saturate at STABLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        scnt_nxt = '0;
        if (qual) begin
            if (scnt == '0 || FSB_A != a_r)
                scnt_nxt = 4'd1;
            else if (scnt >= STABLE_V)
                scnt_nxt = STABLE_V;
            else
                scnt_nxt = scnt + 4'd1;
        end
    end

    always_comb begin
        hit       = '0;
        match_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            hit[i]       = ch_en[i] && (((FSB_A ^ ch_addr[i]) & ch_mask[i]) == '0);
            match_nxt[i] = (scnt_nxt == STABLE_V) && hit[i];
        end
    end

    always_ff @(posedge FSBCLK) begin
        // NOTE: state is written with <= so every register samples pre-edge values.
        if (!nRST) begin
            a_r   <= '0;
            scnt  <= '0;
            MATCH <= '0;
            OUTt  <= 1'b0;
            ch_en <= '0;
            // NOTE: the channel table is reset deliberately; a probe must never match on stale config.
            for (int i = 0; i < NCH; i++) begin
                ch_addr[i] <= '0;
                ch_mask[i] <= '0;
            end
        end else begin
            a_r   <= FSB_A;
            scnt  <= scnt_nxt;
            MATCH <= match_nxt;
            OUTt  <= |match_nxt;
            if (cfg_ok) begin
                ch_en[CFG_CH]   <= CFG_EN;
                ch_addr[CFG_CH] <= CFG_ADDR;
                ch_mask[CFG_CH] <= CFG_MASK;
            end
        end
    end

`ifdef FSB_MATCH_PROBE_HITCNT_EN
    logic [CW-1:0]  hit_cnt [NCH];
    logic [NCH-1:0] rise;

    // One count per bus cycle: only the rising edge of each match flag counts.
    assign rise = match_nxt & ~MATCH;

    always_ff @(posedge FSBCLK) begin
        if (!nRST) begin
            CNT_DATA <= '0;
            for (int i = 0; i < NCH; i++)
                hit_cnt[i] <= '0;
        end else begin
            CNT_DATA <= (int'(CNT_CH) < NCH) ? hit_cnt[CNT_CH] : '0;
            for (int i = 0; i < NCH; i++) begin
                if (CNT_CLR)
                    hit_cnt[i] <= '0;
                else if (rise[i] && hit_cnt[i] != '1)
                    hit_cnt[i] <= hit_cnt[i] + CW'(1);
            end
        end
    end
`else
    logic unused_cnt;

    assign unused_cnt = ^{CNT_CLR, CNT_CH};
    assign CNT_DATA   = '0;
`endif

endmodule

// File: tb/tb_fsb_match_probe.sv
// tb_fsb_match_probe: directed scoreboard bench for fsb_match_probe (NCH=4, STABLE=2, CW=4).
// Counter expectations follow FSB_MATCH_PROBE_HITCNT_EN: real counts when defined, 0 otherwise.
module tb_fsb_match_probe;
    localparam int AW     = 32;
    localparam int NCH    = 4;
    localparam int STABLE = 2;
    localparam int CW     = 4;
    localparam int CHW    = 2;
`ifdef FSB_MATCH_PROBE_HITCNT_EN
    localparam bit HAS_CNT = 1'b1;
`else
    localparam bit HAS_CNT = 1'b0;
`endif

    logic           FSBCLK;
    logic           nRST;
    logic           CPU_nAS;
    logic           INt;
    logic [AW-1:0]  FSB_A;
    logic           CFG_WE;
    logic [CHW-1:0] CFG_CH;
    logic           CFG_EN;
    logic [AW-1:0]  CFG_ADDR;
    logic [AW-1:0]  CFG_MASK;
    logic           CNT_CLR;
    logic [CHW-1:0] CNT_CH;
    logic [NCH-1:0] MATCH;
    logic           OUTt;
    logic [CW-1:0]  CNT_DATA;

    fsb_match_probe #(.AW(AW), .NCH(NCH), .STABLE(STABLE), .CW(CW)) dut (
        .FSBCLK(FSBCLK), .nRST(nRST), .CPU_nAS(CPU_nAS), .INt(INt), .FSB_A(FSB_A),
        .CFG_WE(CFG_WE), .CFG_CH(CFG_CH), .CFG_EN(CFG_EN), .CFG_ADDR(CFG_ADDR),
        .CFG_MASK(CFG_MASK), .CNT_CLR(CNT_CLR), .CNT_CH(CNT_CH),
        .MATCH(MATCH), .OUTt(OUTt), .CNT_DATA(CNT_DATA)
    );

    initial FSBCLK = 1'b0;
    always #5 FSBCLK = ~FSBCLK;

    typedef struct {
        string          tag;
        logic [NCH-1:0] match;
        logic           outt;
        bit             chk_cnt;
        logic [CW-1:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt_exp(input int v);
        if (!HAS_CNT) return '0;
        return (v > 15) ? CW'(15) : CW'(v);
    endfunction

    // Push the expectation for the coming edge, clock once, then pop and compare.
    task automatic step(input string tag, input logic [NCH-1:0] m,
                        input bit chk = 1'b0, input int c = 0);
        exp_t e;
        exp_t got;
        e.tag     = tag;
        e.match   = m;
        e.outt    = |m;
        e.chk_cnt = chk;
        e.cnt     = cnt_exp(c);
        sb.push_back(e);
        @(posedge FSBCLK);
        #1;
        got = sb.pop_front();
        check({got.tag, ".match"}, 32'(MATCH), 32'(got.match));
        check({got.tag, ".outt"}, 32'(OUTt), 32'(got.outt));
        if (got.chk_cnt)
            check({got.tag, ".cnt"}, 32'(CNT_DATA), 32'(got.cnt));
    endtask

    task automatic cfg(input logic [CHW-1:0] ch, input logic en, input logic [AW-1:0] addr,
                       input logic [AW-1:0] mask, input string tag, input logic [NCH-1:0] m);
        CFG_WE   = 1'b1;
        CFG_CH   = ch;
        CFG_EN   = en;
        CFG_ADDR = addr;
        CFG_MASK = mask;
        step(tag, m);
        CFG_WE   = 1'b0;
    endtask

    task automatic rd(input logic [CHW-1:0] ch, input int c, input string tag);
        CNT_CH = ch;
        step(tag, '0, 1'b1, c);
        CNT_CH = '0;
    endtask

    task automatic bus(input logic nas, input logic it, input logic [AW-1:0] a);
        CPU_nAS = nas;
        INt     = it;
        FSB_A   = a;
    endtask

    initial begin
        CFG_WE = 1'b0; CFG_CH = '0; CFG_EN = 1'b0; CFG_ADDR = '0; CFG_MASK = '0;
        CNT_CLR = 1'b0; CNT_CH = '0;
        bus(1'b0, 1'b1, 32'h0000_1234);

        // Reset must beat a config write, a counter clear and a qualified strobe.
        nRST = 1'b0; CNT_CLR = 1'b1;
        CFG_WE = 1'b1; CFG_CH = 2'd0; CFG_EN = 1'b1; CFG_ADDR = 32'h0000_1234; CFG_MASK = '1;
        step("rst", 4'b0000, 1'b1, 0);
        nRST = 1'b1; CNT_CLR = 1'b0; CFG_WE = 1'b0;
        for (int i = 0; i < 3; i++) step("rst_nocfg", 4'b0000);
        bus(1'b1, 1'b0, '0);
        rd(2'd0, 0, "rd_rst");

        // Exact match on ch0, steady address.
        cfg(2'd0, 1'b1, 32'h50F1_4000, 32'hFFFF_FFFF, "cfg0", 4'b0000);
        bus(1'b0, 1'b1, 32'h50F1_4000);
        step("m1_e1", 4'b0000);
        step("m1_e2", 4'b0001);
        step("m1_e3", 4'b0001);
        step("m1_e4", 4'b0001);
        bus(1'b1, 1'b1, 32'h50F1_4000);
        step("m1_neg", 4'b0000);

        // Address wobble drops and then re-asserts the match.
        bus(1'b0, 1'b1, 32'h50F1_4000);
        step("m2_e1", 4'b0000);
        step("m2_e2", 4'b0001);
        FSB_A = 32'h50F1_4004;
        step("m2_chg", 4'b0000);
        FSB_A = 32'h50F1_4000;
        step("m2_back1", 4'b0000);
        step("m2_back2", 4'b0001);
        bus(1'b1, 1'b1, 32'h50F1_4000);
        step("m2_neg", 4'b0000);
        rd(2'd0, 3, "rd_ch0_a");

        // Masked ch1 plus a wildcard ch2 written mid-cycle (old config applies at that edge).
        cfg(2'd1, 1'b1, 32'h5000_0000, 32'hFFF0_0000, "cfg1", 4'b0000);
        bus(1'b0, 1'b1, 32'h500F_FFFC);
        step("m3_e1", 4'b0000);
        cfg(2'd2, 1'b1, 32'h0000_0000, 32'h0000_0000, "m3_cfg2", 4'b0010);
        step("m3_e3", 4'b0110);
        FSB_A = 32'h5010_0000;
        step("m3_out1", 4'b0000);
        step("m3_out2", 4'b0100);
        bus(1'b1, 1'b1, 32'h5010_0000);
        step("m3_neg", 4'b0000);
        cfg(2'd2, 1'b0, 32'h0000_0000, 32'h0000_0000, "cfg2_off", 4'b0000);
        rd(2'd1, 1, "rd_ch1");
        rd(2'd2, 2, "rd_ch2");
        rd(2'd3, 0, "rd_ch3");

        // Unqualified strobe holds SCNT at 0: qualifying later still needs STABLE edges.
        bus(1'b0, 1'b0, 32'h50F1_4000);
        for (int i = 0; i < 3; i++) step("int0", 4'b0000);
        INt = 1'b1;
        step("int1_e1", 4'b0000);
        step("int1_e2", 4'b0001);
        bus(1'b1, 1'b1, 32'h50F1_4000);
        step("int1_neg", 4'b0000);
        rd(2'd0, 4, "rd_ch0_b");

        // Twenty separate bus cycles saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            CPU_nAS = 1'b0;
            step("burst_e1", 4'b0000);
            step("burst_e2", 4'b0001);
            CPU_nAS = 1'b1;
            step("burst_neg", 4'b0000);
        end
        rd(2'd0, 24, "rd_sat");

        // Clear on the same edge as a rising match: clear wins.
        CPU_nAS = 1'b0;
        step("clr_e1", 4'b0000, 1'b1, 24);
        CNT_CLR = 1'b1;
        step("clr_rise", 4'b0001, 1'b1, 24);
        CNT_CLR = 1'b0;
        step("clr_after1", 4'b0001, 1'b1, 0);
        step("clr_after2", 4'b0001, 1'b1, 0);
        CPU_nAS = 1'b1;
        step("clr_neg", 4'b0000, 1'b1, 0);
        rd(2'd1, 0, "rd_ch1_clr");

        // One-clock reset during an active match wipes config and counters.
        bus(1'b0, 1'b1, 32'h50F1_4000);
        step("r2_e1", 4'b0000);
        step("r2_e2", 4'b0001);
        nRST = 1'b0;
        step("r2_rst", 4'b0000, 1'b1, 0);
        nRST = 1'b1;
        step("r2_post1", 4'b0000);
        step("r2_post2", 4'b0000, 1'b1, 0);
        step("r2_post3", 4'b0000);
        cfg(2'd0, 1'b1, 32'h50F1_4000, 32'hFFFF_FFFF, "r2_recfg", 4'b0000);
        step("r2_rematch", 4'b0001);
        bus(1'b1, 1'b1, 32'h50F1_4000);
        step("r2_neg", 4'b0000);
        rd(2'd0, 1, "rd_r2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fsb_match_probe.md
FSB_MATCH_PROBE -- requirements
Module: fsb_match_probe

Interface
REQ-001 Parameter AW, default 32: FSB address width compared.
REQ-002 Parameter NCH, default 4: number of independent match channels (1..16).
REQ-003 Parameter STABLE, default 2: consecutive qualified cycles with unchanged address required before a match (1..15).
REQ-004 Parameter CW, default 16: per-channel hit counter width; CHW = max(1, clog2(NCH)).
REQ-005 FSBCLK  in  1  sole clock; all state updates on its rising edge.
REQ-006 nRST  in  1  reset, synchronous and active-low.
REQ-007 CPU_nAS  in  1  CPU address strobe, active-low.
REQ-008 INt  in  1  qualify input; a cycle is qualified when ~CPU_nAS && INt.
REQ-009 FSB_A  in  AW  FSB address.
REQ-010 CFG_WE, CFG_CH[CHW], CFG_EN, CFG_ADDR[AW], CFG_MASK[AW]  in  channel configuration write port.
REQ-011 CNT_CLR  in  1  clears all hit counters.
REQ-012 CNT_CH  in  CHW  hit counter read select.
REQ-013 MATCH  out  NCH  registered per-channel match flags.
REQ-014 OUTt  out  1  registered OR of all next-cycle MATCH bits.
REQ-015 CNT_DATA  out  CW  registered hit count of channel CNT_CH.

Function
REQ-016 A_r SHALL register FSB_A every cycle.
REQ-017 Stability counter SCNT (saturating at STABLE) SHALL update: unqualified -> 0; qualified and (SCNT==0 or FSB_A!=A_r) -> 1; otherwise min(SCNT+1, STABLE).
REQ-018 Channel i hits when CFG_EN[i]=1 and ((FSB_A ^ ADDR[i]) & MASK[i])==0; MASK bit 1 = bit compared, MASK=0 matches any address.
REQ-019 MATCH[i] SHALL be loaded with (next SCNT==STABLE) && hit(i): it rises on the STABLE-th qualified edge with a steady address and falls on the edge after strobe negation or an address change.
REQ-020 OUTt SHALL equal |MATCH at all times, registered as well (not gated combinationally from MATCH).
REQ-021 A configuration write (CFG_WE=1, CFG_CH<NCH) SHALL update channel CFG_CH's EN/ADDR/MASK at the edge; the match evaluated at that same edge uses the old values; CFG_CH>=NCH is ignored.
REQ-022 HIT[i] SHALL increment by one on each rising transition of MATCH[i] (one count per bus cycle, not per clock), saturating at 2^CW-1.
REQ-023 CNT_CLR SHALL zero all HIT counters; on a simultaneous clear and increment, the counter becomes 0.
REQ-024 CNT_DATA SHALL be loaded with HIT[CNT_CH] (pre-update value) each cycle, giving one-cycle read latency; CNT_CH>=NCH reads 0.
REQ-025 With STABLE=1, NCH=1, and MASK all ones, MATCH[0] SHALL equal the registered value of ~CPU_nAS && INt && (FSB_A==ADDR[0]).

Reset
REQ-026 When nRST=0 at an edge: A_r, SCNT, MATCH, OUTt, CNT_DATA, and all HIT SHALL become 0, and all EN, ADDR, and MASK SHALL become 0.
REQ-027 Reset SHALL dominate configuration writes, CNT_CLR, and mid-cycle qualified strobes; after release, a strobe already active counts from SCNT=0.

Configuration
REQ-028 Macro FSB_MATCH_PROBE_HITCNT_EN defined: HIT counters, CNT_CLR, and CNT_DATA behave per REQ-022..024.
REQ-029 Macro not defined: no counter registers exist, CNT_CLR and CNT_CH are ignored, and CNT_DATA is tied to 0; MATCH and OUTt are unchanged.

Verification
REQ-030 Reset, then write ch0 EN=1 ADDR=0x50F1_4000 MASK=0xFFFF_FFFF; hold nAS=0 INt=1 A=0x50F1_4000 for 4 clocks -> MATCH[0]=1 from the 2nd edge onward and OUTt=1 in the same cycles.
REQ-031 Same setup, A changes to 0x50F1_4004 on the 3rd clock -> MATCH[0] drops on that edge; if returned to 0x50F1_4000, it re-asserts 2 edges later and HIT[0] increments by 2.
REQ-032 Ch1 EN=1 ADDR=0x5000_0000 MASK=0xFFF0_0000; stable A=0x500F_FFFC -> MATCH[1]=1; A=0x5010_0000 -> MATCH[1]=0.
REQ-033 INt=0 with nAS=0 and matching address -> MATCH=0, SCNT=0, and no HIT increment.
REQ-034 CW=4 (macro on): 20 separate matching bus cycles -> CNT_DATA=15; CNT_CLR asserted on an edge where MATCH[0] rises -> CNT_DATA=0 two cycles later.
REQ-035 nRST=0 for one clock during an active match -> MATCH=0, OUTt=0, and all configuration cleared; MATCH stays 0 with the strobe still active until channels are reconfigured.
